// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution controller: ALU op codes, MIPS
// opcode/funct values, FSM states and the instruction decode helper.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic       use_imm;
    logic       sign_ext;
    logic       wr_en;
    logic       dest_rd;
    logic       is_beq;
  } dec_t;

  function automatic dec_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d.legal    = 1'b1;
    d.op       = ALU_ADD;
    d.use_imm  = 1'b1;
    d.sign_ext = 1'b1;
    d.wr_en    = 1'b1;
    d.dest_rd  = 1'b0;
    d.is_beq   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d.use_imm = 1'b0;
        d.dest_rd = 1'b1;
        case (funct)
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_ADD:  d.op = ALU_ADD;
          FN_SUB:  d.op = ALU_SUB;
          FN_SLT:  d.op = ALU_SLT;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDI: d.op = ALU_ADD;
      OP_SLTI: d.op = ALU_SLT;
      OP_ANDI: begin
        d.op       = ALU_AND;
        d.sign_ext = 1'b0;
      end
      OP_ORI: begin
        d.op       = ALU_OR;
        d.sign_ext = 1'b0;
      end
      OP_BEQ: begin
        d.op      = ALU_SUB;
        d.use_imm = 1'b0;
        d.wr_en   = 1'b0;
        d.is_beq  = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d.wr_en = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two async read ports, async debug read, one sync
// write port. Register 0 is never written so it always reads zero.
module reg_file_32x32 (
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle MIPS subset controller driving an external 32-bit ALU and
// writing results back into a local register file.
//
// state    | meaning
// S_IDLE   | InstrReady high, waiting for an instruction
// S_DECODE | decode, read rs/rt, register ALU operands
// S_EXEC   | ALU operands stable, sample ALU outputs at closing edge
// S_WB     | write back, publish results, pulse Done
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instr,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [2:0]  AluOp,
  input  logic [31:0] AluResult,
  input  logic        AluZero,
  input  logic        AluCarryOut,
  output logic        Done,
  output logic [31:0] ResultOut,
  output logic        ZeroOut,
  output logic        CarryOut,
  output logic        BrTaken,
  output logic        Illegal,
  input  logic [4:0]  DbgAddr,
  output logic [31:0] DbgData
);

  state_t      state;
  logic [31:0] instr_q;
  logic        legal_q;
  logic        wr_q;
  logic        beq_q;
  logic [4:0]  dest_q;
  logic [31:0] res_q;
  logic        zero_q;
  logic        carry_q;

  dec_t        dec;
  logic [31:0] imm_ext;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        rf_we;
  logic        carry_en;

  assign dec     = decode_instr(instr_q[31:26], instr_q[5:0]);
  assign imm_ext = dec.sign_ext ? {{16{instr_q[15]}}, instr_q[15:0]}
                                : {16'h0000, instr_q[15:0]};

  // Write lands on the edge leaving WB, so an instruction accepted right
  // after Done already sees the new value at DECODE.
  assign rf_we    = (state == S_WB) && wr_q;
  assign carry_en = (AluOp == ALU_ADD) || (AluOp == ALU_SUB);

  assign InstrReady = (state == S_IDLE);

  reg_file_32x32 u_rf (
    .clk_sys  (Clk),
    .rst_b    (Reset_n),
    .we       (rf_we),
    .waddr    (dest_q),
    .wdata    (res_q),
    .raddr_a  (instr_q[25:21]),
    .rdata_a  (rdata_a),
    .raddr_b  (instr_q[20:16]),
    .rdata_b  (rdata_b),
    .dbg_addr (DbgAddr),
    .dbg_data (DbgData)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      instr_q   <= '0;
      legal_q   <= 1'b0;
      wr_q      <= 1'b0;
      beq_q     <= 1'b0;
      dest_q    <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      AluA      <= '0;
      AluB      <= '0;
      AluOp     <= ALU_AND;
      Done      <= 1'b0;
      ResultOut <= '0;
      ZeroOut   <= 1'b0;
      CarryOut  <= 1'b0;
      BrTaken   <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (InstrValid) begin
            instr_q <= Instr;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          legal_q <= dec.legal;
          wr_q    <= dec.wr_en;
          beq_q   <= dec.is_beq;
          dest_q  <= dec.dest_rd ? instr_q[15:11] : instr_q[20:16];
          if (dec.legal) begin
            AluA  <= rdata_a;
            AluB  <= dec.use_imm ? imm_ext : rdata_b;
            AluOp <= dec.op;
            state <= S_EXEC;
          end else begin
            state <= S_WB;
          end
        end
        S_EXEC: begin
          res_q   <= AluResult;
          zero_q  <= AluZero;
          carry_q <= AluCarryOut;
          state   <= S_WB;
        end
        S_WB: begin
          Done    <= 1'b1;
          Illegal <= !legal_q;
          if (legal_q) begin
            ResultOut <= res_q;
            ZeroOut   <= zero_q;
            CarryOut  <= carry_en ? carry_q : 1'b0;
            BrTaken   <= beq_q && zero_q;
          end else begin
            ResultOut <= '0;
            ZeroOut   <= 1'b0;
            CarryOut  <= 1'b0;
            BrTaken   <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized self-checking bench for alu_exec_ctrl with a behavioural ALU
// attached and an instruction-level reference model of the register file.
module tb_alu_exec_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [2:0]  AluOp;
  logic [31:0] AluResult;
  logic        AluZero;
  logic        AluCarryOut;
  logic        Done;
  logic [31:0] ResultOut;
  logic        ZeroOut;
  logic        CarryOut;
  logic        BrTaken;
  logic        Illegal;
  logic [4:0]  DbgAddr;
  logic [31:0] DbgData;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rf [32];

  typedef struct packed {
    logic        illegal;
    logic        br;
    logic        zero;
    logic        carry;
    logic        wr;
    logic [4:0]  dest;
    logic [31:0] result;
  } exp_t;

  alu_exec_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Instr       (Instr),
    .AluA        (AluA),
    .AluB        (AluB),
    .AluOp       (AluOp),
    .AluResult   (AluResult),
    .AluZero     (AluZero),
    .AluCarryOut (AluCarryOut),
    .Done        (Done),
    .ResultOut   (ResultOut),
    .ZeroOut     (ZeroOut),
    .CarryOut    (CarryOut),
    .BrTaken     (BrTaken),
    .Illegal     (Illegal),
    .DbgAddr     (DbgAddr),
    .DbgData     (DbgData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External ALU: SUB carry is the no-borrow flag of A + ~B + 1.
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (AluOp)
      3'b000:  alu_wide = {1'b0, AluA & AluB};
      3'b001:  alu_wide = {1'b0, AluA | AluB};
      3'b010:  alu_wide = {1'b0, AluA} + {1'b0, AluB};
      3'b110:  alu_wide = {1'b0, AluA} + {1'b0, ~AluB} + 33'd1;
      3'b111:  alu_wide = {32'd0, AluA < AluB};
      default: alu_wide = '0;
    endcase
  end
  assign AluResult   = alu_wide[31:0];
  assign AluCarryOut = alu_wide[32];
  assign AluZero     = (alu_wide[31:0] == 32'd0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    rtype = {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    itype = {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Instruction-level semantics straight from the ISA description.
  function automatic exp_t ref_exec(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b, x;
    logic [32:0] s;
    logic        legal;
    e     = '0;
    legal = 1'b1;
    a     = rf[ins[25:21]];
    b     = rf[ins[20:16]];
    x     = b;
    case (ins[31:26])
      6'h00: begin
        e.dest = ins[15:11];
        e.wr   = 1'b1;
        case (ins[5:0])
          6'h24: e.result = a & b;
          6'h25: e.result = a | b;
          6'h20: begin s = {1'b0, a} + {1'b0, b}; e.result = s[31:0]; e.carry = s[32]; end
          6'h22: begin e.result = a - b; e.carry = (a >= b); end
          6'h2A: e.result = (a < b) ? 32'd1 : 32'd0;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin
        x = {{16{ins[15]}}, ins[15:0]};
        s = {1'b0, a} + {1'b0, x};
        e.result = s[31:0]; e.carry = s[32]; e.wr = 1'b1; e.dest = ins[20:16];
      end
      6'h0A: begin
        x = {{16{ins[15]}}, ins[15:0]};
        e.result = (a < x) ? 32'd1 : 32'd0; e.wr = 1'b1; e.dest = ins[20:16];
      end
      6'h0C: begin e.result = a & {16'd0, ins[15:0]}; e.wr = 1'b1; e.dest = ins[20:16]; end
      6'h0D: begin e.result = a | {16'd0, ins[15:0]}; e.wr = 1'b1; e.dest = ins[20:16]; end
      6'h04: begin e.result = a - b; e.carry = (a >= b); e.br = (a == b); end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
      e.illegal = 1'b1;
    end else begin
      e.zero = (e.result == 32'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5];
    logic [5:0] iops [4];
    logic [5:0] bad_ops [4];
    logic [5:0] bad_fns [4];
    int k, rs, rt, rd;
    logic [15:0] imm;
    fns     = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
    iops    = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    bad_ops = '{6'h3F, 6'h02, 6'h23, 6'h2B};
    bad_fns = '{6'h00, 6'h21, 6'h26, 6'h2B};
    k   = $urandom_range(0, 9);
    rs  = $urandom_range(0, 7);
    rt  = $urandom_range(0, 7);
    rd  = $urandom_range(0, 7);
    imm = 16'($urandom);
    if (k <= 3)      rand_instr = rtype(rs, rt, rd, fns[$urandom_range(0, 4)]);
    else if (k <= 6) rand_instr = itype(iops[$urandom_range(0, 3)], rs, rt, imm);
    else if (k == 7) rand_instr = itype(6'h04, rs, rt, imm);
    else if (k == 8) rand_instr = itype(bad_ops[$urandom_range(0, 3)], rs, rt, imm);
    else             rand_instr = rtype(rs, rt, rd, bad_fns[$urandom_range(0, 3)]);
  endfunction

  task automatic check_all_regs(input string tag);
    for (int r = 0; r < 32; r++) begin
      DbgAddr = 5'(r);
      #1;
      chk(tag, DbgData, rf[r]);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    exp_t e;
    int   cyc;
    e   = ref_exec(ins);
    cyc = 0;
    @(negedge Clk);
    while (!InstrReady && cyc < 8) begin
      @(negedge Clk);
      cyc++;
    end
    chk("ready", 32'(InstrReady), 32'd1);
    InstrValid = 1'b1;
    Instr      = ins;
    @(posedge Clk);
    #1;
    InstrValid = 1'b0;
    Instr      = $urandom;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
      if (!Done) chk("busy_ready", 32'(InstrReady), 32'd0);
    end while (!Done && cyc < 8);
    chk("latency", 32'(cyc - 1), e.illegal ? 32'd2 : 32'd3);
    chk("result", ResultOut, e.result);
    chk("zero", 32'(ZeroOut), 32'(e.zero));
    chk("carry", 32'(CarryOut), 32'(e.carry));
    chk("brtaken", 32'(BrTaken), 32'(e.br));
    chk("illegal", 32'(Illegal), 32'(e.illegal));
    if (e.wr && e.dest != 5'd0) rf[e.dest] = e.result;
    DbgAddr = e.dest;
    #1;
    chk("wb_data", DbgData, rf[e.dest]);
    @(negedge Clk);
    chk("done_pulse", 32'(Done), 32'd0);
    chk("result_hold", ResultOut, e.result);
    chk("illegal_hold", 32'(Illegal), 32'(e.illegal));
  endtask

  initial begin
    int accepts, last;
    Reset_n    = 1'b0;
    InstrValid = 1'b0;
    Instr      = '0;
    DbgAddr    = '0;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    repeat (2) @(negedge Clk);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_result", ResultOut, 32'd0);
    chk("rst_alua", AluA, 32'd0);
    chk("rst_alub", AluB, 32'd0);
    chk("rst_aluop", 32'(AluOp), 32'd0);
    chk("rst_flags", {28'd0, ZeroOut, CarryOut, BrTaken, Illegal}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_ready", 32'(InstrReady), 32'd1);

    issue(itype(6'h08, 0, 1, 16'h7FFF));
    issue(itype(6'h08, 0, 2, 16'hFFFF));
    DbgAddr = 5'd1; #1; chk("r1_7fff", DbgData, 32'h00007FFF);
    DbgAddr = 5'd2; #1; chk("r2_ffff", DbgData, 32'hFFFFFFFF);
    issue(rtype(2, 2, 3, 6'h20));
    chk("add_res", ResultOut, 32'hFFFFFFFE);
    chk("add_carry", 32'(CarryOut), 32'd1);
    issue(rtype(1, 1, 4, 6'h22));
    chk("sub_zero", 32'(ZeroOut), 32'd1);
    issue(itype(6'h04, 1, 1, 16'h0010));
    chk("beq_taken", 32'(BrTaken), 32'd1);
    issue(itype(6'h04, 1, 2, 16'h0010));
    chk("beq_not", 32'(BrTaken), 32'd0);
    issue(rtype(1, 1, 0, 6'h20));
    issue(itype(6'h3F, 1, 5, 16'h1234));
    chk("ill_flag", 32'(Illegal), 32'd1);
    check_all_regs("dir_regs");

    for (int n = 0; n < 60; n++) issue(rand_instr());
    check_all_regs("rnd_regs");

    // Back-to-back offers: BEQ writes nothing, so the model stays valid.
    accepts = 0;
    last    = 0;
    InstrValid = 1'b1;
    Instr      = itype(6'h04, 1, 1, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge Clk);
      if (InstrReady) begin
        if (accepts > 0) chk("tput_gap", 32'(i - last), 32'd4);
        accepts++;
        last = i;
      end
    end
    @(negedge Clk);
    InstrValid = 1'b0;
    chk("tput_count", 32'(accepts), 32'd10);
    repeat (6) @(negedge Clk);

    issue(itype(6'h08, 0, 1, 16'h0005));
    @(negedge Clk);
    chk("exec_ready", 32'(InstrReady), 32'd1);
    InstrValid = 1'b1;
    Instr      = rtype(1, 1, 5, 6'h20);
    @(posedge Clk);
    #1;
    InstrValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("exec_alua", AluA, rf[1]);
    Reset_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    chk("mid_done", 32'(Done), 32'd0);
    chk("mid_result", ResultOut, 32'd0);
    chk("mid_alua", AluA, 32'd0);
    chk("mid_alub", AluB, 32'd0);
    chk("mid_aluop", 32'(AluOp), 32'd0);
    chk("mid_ready", 32'(InstrReady), 32'd1);
    DbgAddr = 5'd5; #1; chk("mid_r5", DbgData, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("no_done", 32'(Done), 32'd0);
    end
    check_all_regs("post_rst");
    issue(itype(6'h0D, 0, 6, 16'hA5A5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have port: Clk  input  1  rising-edge clock.
REQ-002 SHALL have port: Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: InstrValid  input  1  instruction word offered.
REQ-004 SHALL have port: InstrReady  output  1  block accepts instruction (accept = InstrValid & InstrReady at Clk edge).
REQ-005 SHALL have port: Instr  input  32  MIPS instruction word.
REQ-006 SHALL have ports: AluA, AluB  output  32 each; AluOp  output  3  operands and op driven to the downstream 32-bit ALU.
REQ-007 SHALL have ports: AluResult  input  32; AluZero, AluCarryOut  input  1 each  combinational ALU outputs.
REQ-008 SHALL have ports: Done  output  1  one-cycle completion pulse; ResultOut  output  32; ZeroOut, CarryOut  output  1; BrTaken  output  1; Illegal  output  1.
REQ-009 SHALL have ports: DbgAddr  input  5; DbgData  output  32  combinational register-file read for test.

Function
REQ-010 SHALL hold 32x32-bit register file; register 0 reads 0, writes to it discarded.
REQ-011 SHALL run FSM IDLE -> DECODE -> EXEC -> WB -> IDLE; InstrReady=1 only in IDLE.
REQ-012 SHALL in IDLE on accept latch Instr and go to DECODE; otherwise stay.
REQ-013 SHALL in DECODE read rs[25:21], rt[20:16], register AluA, AluB, AluOp, go to EXEC; illegal encodings go directly to WB.
REQ-014 SHALL decode R-type (opcode 000000) funct: 100100 AND->000, 100101 OR->001, 100000 ADD->010, 100010 SUB->110, 101010 SLT->111; destination rd[15:11]; AluB=R[rt].
REQ-015 SHALL decode I-type: ADDI 001000->010 sign-ext imm; SLTI 001010->111 sign-ext; ANDI 001100->000 zero-ext; ORI 001101->001 zero-ext; destination rt; AluB=extended imm[15:0].
REQ-016 SHALL decode BEQ 000100 as SUB of R[rs], R[rt], no register write, BrTaken=AluZero.
REQ-017 SHALL treat every other opcode/funct as illegal: no ALU use, no write, Illegal=1, ResultOut=0.
REQ-018 SHALL in EXEC hold AluA/AluB/AluOp stable and sample AluResult, AluZero, AluCarryOut at the closing Clk edge.
REQ-019 SHALL in WB write sampled result to destination (if write-enabled, nonzero), assert Done for exactly one cycle with ResultOut/ZeroOut/CarryOut/BrTaken/Illegal valid, return to IDLE.
REQ-020 SHALL hold ResultOut, ZeroOut, CarryOut, BrTaken, Illegal stable after Done until next WB.
REQ-021 SHALL give latency: accept at edge N -> Done high cycle N+3 (legal), N+2 (illegal); throughput one instruction per 4 cycles max.
REQ-022 SHALL use ALU values unmodified: SLT/SLTI compare as the ALU does (unsigned), CarryOut valid only for ADD/SUB, 0 otherwise.
REQ-023 SHALL ignore InstrValid outside IDLE; Instr need not be held after accept.
REQ-024 SHALL give WB write precedence: instruction accepted in cycle after Done reads updated register.

Reset
REQ-025 SHALL on Reset_n=0, asynchronously: FSM IDLE, all 32 registers 0, AluA=AluB=0, AluOp=000, Done=0, ResultOut=0, ZeroOut=0, CarryOut=0, BrTaken=0, Illegal=0; InstrReady=1 after release.
REQ-026 SHALL abandon any in-flight instruction on reset mid-operation with no register write and no Done.

Structure
REQ-027 SHALL place ALU op codes (AND/OR/ADD/SUB/SLT), opcode/funct constants and FSM state encoding in shared package alu_pkg.
REQ-028 SHALL implement register file as sub-module reg_file_32x32 (two async read ports + debug port, one sync write port, async reset).
REQ-029 SHALL not contain the ALU; ALU connects externally via REQ-006/007.

Verification
REQ-030 SHALL cover: ADDI $1,$0,0x7FFF then ADDI $2,$0,-1 -> DbgData[1]=0x00007FFF, DbgData[2]=0xFFFFFFFF, Done 3 cycles after each accept.
REQ-031 SHALL cover: ADD $3,$2,$2 with $2=0xFFFFFFFF -> ResultOut=0xFFFFFFFE, CarryOut=1; SUB $4,$1,$1 -> ResultOut=0, ZeroOut=1.
REQ-032 SHALL cover: BEQ $1,$1 -> BrTaken=1, no register changed; BEQ $1,$2 -> BrTaken=0.
REQ-033 SHALL cover: ADD $0,$1,$1 -> DbgData[0]=0; opcode 111111 -> Illegal=1, Done 2 cycles after accept, no write.
REQ-034 SHALL cover: InstrValid held high continuously -> exactly one accept per 4 cycles, InstrReady low in DECODE/EXEC/WB.
REQ-035 SHALL cover: Reset_n low during EXEC of ADD $5,$1,$1 -> no Done, $5=0, outputs at reset values immediately.
